// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package rr_arb_pkg;

   // Controller states: no owner, owner granted, one-cycle dead gap after release.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Width needed to count 0..max_hold inclusive.
   function automatic int hold_width(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_hold_arbiter_if #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   req;
   logic [N-1:0]   grnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           preempt;

   // Requester side: raises requests, observes grants.
   modport master (
      output req,
      input  grnt, gnt_id, busy, preempt
   );

   // Arbiter side: observes requests, drives grants.
   modport slave (
      input  req,
      output grnt, gnt_id, busy, preempt
   );
endinterface : rr_hold_arbiter_if

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] win_id,
   output logic [N-1:0]   win_onehot
);

   // Scan from the farthest offset back to ptr so the nearest request wins last.
   always_comb begin
      logic [IDW-1:0] idx;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      any        = 1'b0;
      win_id     = '0;
      win_onehot = '0;
      idx        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            any    = 1'b1;
            win_id = idx;
         end
      end
      if (any) begin
         win_onehot = N'(1) << win_id;
      end
   end

endmodule : rr_pick

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant hold and a hold-time limit under contention.
module rr_hold_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDW      = $clog2(N),
   localparam int HW       = hold_width(MAX_HOLD)
) (
   input logic                clk,
   input logic                rst,
   rr_hold_arbiter_if.slave   bus
);

   state_t         state;
   logic [N-1:0]   grnt_q;
   logic [IDW-1:0] gnt_id_q;
   logic           busy_q;
   logic           preempt_q;
   logic [IDW-1:0] ptr;
   logic [HW-1:0]  hold_cnt;

   logic           pick_any;
   logic [IDW-1:0] pick_id;
   logic [N-1:0]   pick_onehot;

   logic           owner_req;
   logic           others_req;
   logic           hold_full;
   logic [IDW-1:0] next_ptr;

   rr_pick #(.N(N)) u_pick (
      .req        (bus.req),
      .ptr        (ptr),
      .any        (pick_any),
      .win_id     (pick_id),
      .win_onehot (pick_onehot)
   );

   assign owner_req  = bus.req[gnt_id_q];
   assign others_req = |(bus.req & ~grnt_q);
   assign hold_full  = (hold_cnt == HW'(MAX_HOLD));
   assign next_ptr   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

   // Grant controller: picks in IDLE/GAP, holds or releases in GRANT; all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         grnt_q    <= '0;
         gnt_id_q  <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         preempt_q <= 1'b0;
         case (state)
            IDLE, GAP: begin
               if (pick_any) begin
                  grnt_q   <= pick_onehot;
                  gnt_id_q <= pick_id;
                  busy_q   <= 1'b1;
                  hold_cnt <= HW'(1);
                  state    <= GRANT;
               end else begin
                  state    <= IDLE;
               end
            end
            GRANT: begin
               if (!owner_req || (hold_full && others_req)) begin
                  // A dropped request wins over the limit, so preempt flags only forced releases.
                  grnt_q    <= '0;
                  busy_q    <= 1'b0;
                  ptr       <= next_ptr;
                  hold_cnt  <= '0;
                  preempt_q <= owner_req;
                  state     <= GAP;
               end else if (!hold_full) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               grnt_q   <= '0;
               busy_q   <= 1'b0;
               hold_cnt <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.grnt    = grnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.busy    = busy_q;
   assign bus.preempt = preempt_q;

endmodule : rr_hold_arbiter

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench: two arbiters (hold limits 8 and 2) share one request bus and
// are compared every cycle against a cycle-level ownership model.
module tb_rr_hold_arbiter;

   localparam int N = 4;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   rr_hold_arbiter_if #(.N(N)) if_a ();
   rr_hold_arbiter_if #(.N(N)) if_b ();

   rr_hold_arbiter #(.N(N), .MAX_HOLD(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   rr_hold_arbiter #(.N(N), .MAX_HOLD(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

   logic [N-1:0] req;
   assign if_a.req = req;
   assign if_b.req = req;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: who owns the resource, for how many cycles, where the search starts.
   typedef struct {
      int owner;
      int run;
      int ptr;
      bit pre;
   } mstate_t;

   mstate_t m [2];
   int      mh [2] = '{8, 2};

   function automatic int pick(input logic [N-1:0] r, input int p);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) begin
         t = r >> ((p + k) % N);
         if (t[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic mstate_t model_next(input mstate_t s, input logic [N-1:0] r, input int lim);
      mstate_t      n;
      logic [N-1:0] mine;
      logic [N-1:0] t;
      int           w;
      n     = s;
      n.pre = 1'b0;
      if (s.owner >= 0) begin
         mine = N'(1) << s.owner;
         t    = r >> s.owner;
         if (!t[0] || (s.run >= lim && (r & ~mine) != 0)) begin
            n.pre   = t[0];
            n.ptr   = (s.owner + 1) % N;
            n.owner = -1;
            n.run   = 0;
         end else begin
            n.run = s.run + 1;
         end
      end else begin
         w = pick(r, s.ptr);
         if (w >= 0) begin
            n.owner = w;
            n.run   = 1;
         end
      end
      return n;
   endfunction

   // Advance the model on every clock edge; reset mirrors the DUT's async reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) m[d] <= '{owner: -1, run: 0, ptr: 0, pre: 1'b0};
      end else begin
         for (int d = 0; d < 2; d++) m[d] <= model_next(m[d], req, mh[d]);
      end
   end

   // Per-cycle comparison against the model plus the structural invariants.
   always @(negedge clk) begin
      logic [N-1:0] eg [2];
      logic [N-1:0] g  [2];
      logic [1:0]   id [2];
      logic         bz [2];
      logic         pr [2];
      if (rst) begin
         g[0] = if_a.grnt; id[0] = if_a.gnt_id; bz[0] = if_a.busy; pr[0] = if_a.preempt;
         g[1] = if_b.grnt; id[1] = if_b.gnt_id; bz[1] = if_b.busy; pr[1] = if_b.preempt;
         for (int d = 0; d < 2; d++) begin
            eg[d] = (m[d].owner >= 0) ? (N'(1) << m[d].owner) : '0;
            total++;
            if (g[d] !== eg[d]) begin
               bad++;
               $display("FAIL model_grnt dut%0d t=%0t got=%b exp=%b", d, $time, g[d], eg[d]);
            end
            total++;
            if (pr[d] !== m[d].pre) begin
               bad++;
               $display("FAIL model_preempt dut%0d t=%0t got=%b exp=%b", d, $time, pr[d], m[d].pre);
            end
            total++;
            if (bz[d] !== (|g[d]) || !$onehot0(g[d])) begin
               bad++;
               $display("FAIL inv_busy_onehot dut%0d t=%0t grnt=%b busy=%b", d, $time, g[d], bz[d]);
            end
            if (bz[d] === 1'b1) begin
               total++;
               if (g[d][id[d]] !== 1'b1 || id[d] !== 2'(m[d].owner)) begin
                  bad++;
                  $display("FAIL inv_gnt_id dut%0d t=%0t gnt_id=%0d grnt=%b exp_id=%0d",
                           d, $time, id[d], g[d], m[d].owner);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = '0;
      #12;
      total++;
      if (if_a.grnt !== 4'b0 || if_a.busy !== 1'b0 || if_a.preempt !== 1'b0 || if_a.gnt_id !== 2'd0) begin
         bad++;
         $display("FAIL reset_state got grnt=%b busy=%b pre=%b id=%0d exp all zero",
                  if_a.grnt, if_a.busy, if_a.preempt, if_a.gnt_id);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      req = 4'b0100;
      step();
      total++;
      if (if_a.grnt !== 4'b0100 || if_a.gnt_id !== 2'd2 || if_a.busy !== 1'b1) begin
         bad++;
         $display("FAIL single_grant got grnt=%b id=%0d busy=%b exp 0100/2/1",
                  if_a.grnt, if_a.gnt_id, if_a.busy);
      end
      step();
      step();
      req = 4'b0000;
      step();
      total++;
      if (if_a.grnt !== 4'b0000 || if_a.busy !== 1'b0) begin
         bad++;
         $display("FAIL single_release got grnt=%b busy=%b exp 0000/0", if_a.grnt, if_a.busy);
      end
      step();
      step();
      // ptr is now 3: requester 3 must beat requester 0.
      req = 4'b1001;
      step();
      total++;
      if (if_a.grnt !== 4'b1000) begin
         bad++;
         $display("FAIL single_ptr_after got grnt=%b exp 1000", if_a.grnt);
      end
      req = '0;
      step();
      step();
   endtask

   task automatic test_preempt();
      do_reset();
      req = 4'b1010;
      for (int r = 0; r < 2; r++) begin
         logic [N-1:0] own;
         own = (r == 0) ? 4'b0010 : 4'b1000;
         for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (if_a.grnt !== own || if_a.preempt !== 1'b0) begin
               bad++;
               $display("FAIL preempt_hold round=%0d cyc=%0d got grnt=%b pre=%b exp %b/0",
                        r, i, if_a.grnt, if_a.preempt, own);
            end
         end
         step();
         total++;
         if (if_a.grnt !== 4'b0000 || if_a.preempt !== 1'b1) begin
            bad++;
            $display("FAIL preempt_gap round=%0d got grnt=%b pre=%b exp 0000/1",
                     r, if_a.grnt, if_a.preempt);
         end
      end
      step();
      total++;
      if (if_a.grnt !== 4'b0010 || if_a.preempt !== 1'b0) begin
         bad++;
         $display("FAIL preempt_return got grnt=%b pre=%b exp 0010/0", if_a.grnt, if_a.preempt);
      end
   endtask

   task automatic test_sole();
      do_reset();
      req = 4'b0001;
      step();
      for (int i = 0; i < 50; i++) begin
         step();
         total++;
         if (if_a.grnt !== 4'b0001 || if_b.grnt !== 4'b0001 || if_a.preempt || if_b.preempt) begin
            bad++;
            $display("FAIL sole_hold cyc=%0d got a=%b b=%b pre=%b%b exp 0001 no preempt",
                     i, if_a.grnt, if_b.grnt, if_a.preempt, if_b.preempt);
         end
      end
   endtask

   task automatic test_fair();
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] own;
         own = N'(1) << (k % N);
         for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (if_b.grnt !== own) begin
               bad++;
               $display("FAIL fair_grant slot=%0d cyc=%0d got=%b exp=%b", k, i, if_b.grnt, own);
            end
         end
         step();
         total++;
         if (if_b.grnt !== 4'b0000 || if_b.preempt !== 1'b1) begin
            bad++;
            $display("FAIL fair_gap slot=%0d got grnt=%b pre=%b exp 0000/1", k, if_b.grnt, if_b.preempt);
         end
      end
   endtask

   task automatic test_drop_at_max();
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 8; i++) step();
      req = 4'b0010;
      step();
      total++;
      if (if_a.grnt !== 4'b0000 || if_a.preempt !== 1'b0) begin
         bad++;
         $display("FAIL drop_at_max got grnt=%b pre=%b exp 0000/0", if_a.grnt, if_a.preempt);
      end
      step();
      total++;
      if (if_a.grnt !== 4'b0010) begin
         bad++;
         $display("FAIL drop_at_max_next got=%b exp 0010", if_a.grnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 12; i++) step();
      #3;
      rst = 1'b0;
      #1;
      total++;
      if (if_a.grnt !== 4'b0 || if_a.busy || if_a.preempt || if_b.grnt !== 4'b0 || if_b.busy || if_b.preempt) begin
         bad++;
         $display("FAIL async_reset got a=%b/%b/%b b=%b/%b/%b exp all zero",
                  if_a.grnt, if_a.busy, if_a.preempt, if_b.grnt, if_b.busy, if_b.preempt);
      end
      #2;
      rst = 1'b1;
      step();
      total++;
      if (if_a.grnt !== 4'b0001 || if_b.grnt !== 4'b0001) begin
         bad++;
         $display("FAIL async_reset_first got a=%b b=%b exp 0001", if_a.grnt, if_b.grnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(3) == 0) req[b] = ~req[b];
         end
         step();
      end
      req = '0;
      step();
      step();
   endtask

   initial begin
      req = '0;
      test_reset();
      test_single();
      test_preempt();
      test_sole();
      test_fair();
      test_drop_at_max();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rr_hold_arbiter
